multicycle_control: RTL

- Multi-cycle main controller for the MIPS core.
- Accepts one 32-bit instruction at a time through a valid/ready handshake and holds it on `Instr`.
- Sequences the datapath control signals (`Reg_Dst`, `Reg_Write`, `Alu_Src`, `Alu_Control`, `Mem_Write`, `Mem_Read`, `Mem_To_Reg`) through FETCH/DECODE/EXEC/MEM/WB states.
- It is the driving end of the datapath control interface. It consumes the ALU `eq` flag for branch resolution.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/alu_decoder.sv | 24 ++
 rtl/multicycle_control.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, funct, ALU code and state definitions for the MIPS controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to ALU control mapping with unsupported-funct flag
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main controller sequencing FETCH/DECODE/EXEC/MEM/WB
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        eq,
  output logic [31:0] Instr,
  output logic        Reg_Dst,
  output logic        Reg_Write,
  output logic        Alu_Src,
  output logic [3:0]  Alu_Control,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic        Mem_To_Reg,
  output logic        branch_taken,
  output logic        illegal,
  output logic        done
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LATENCY - 1);

  state_t     state, next_state;
  logic [3:0] mem_cnt;

  logic [5:0] opcode;
  logic       is_rtype, is_lw, is_sw, is_addi, is_beq;
  logic [3:0] fn_alu;
  logic       fn_illegal;
  logic       dec_illegal;
  logic [3:0] dec_alu_ctl;

  logic       active;
  logic       reg_dst_d, alu_src_d, mem_to_reg_d;
  logic [3:0] alu_ctl_d;
  logic       reg_write_d, mem_write_d, mem_read_d;
  logic       done_d, illegal_d, branch_d;

  alu_decoder u_alu_decoder (
    .funct       (Instr[5:0]),
    .alu_control (fn_alu),
    .illegal     (fn_illegal)
  );

  // Instr is held for the whole instruction, so decode straight from it in every state.
  assign opcode      = Instr[31:26];
  assign is_rtype    = (opcode == OP_RTYPE);
  assign is_lw       = (opcode == OP_LW);
  assign is_sw       = (opcode == OP_SW);
  assign is_addi     = (opcode == OP_ADDI);
  assign is_beq      = (opcode == OP_BEQ);
  assign dec_illegal = !(is_lw || is_sw || is_addi || is_beq || (is_rtype && !fn_illegal));
  assign dec_alu_ctl = is_rtype ? fn_alu : (is_beq ? ALU_SUB : ALU_ADD);

  assign instr_ready = (state == FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (instr_valid) next_state = DECODE;
      DECODE:  next_state = dec_illegal ? FETCH : EXEC;
      EXEC: begin
        if (is_beq)              next_state = FETCH;
        else if (is_lw || is_sw) next_state = MEM;
        else                     next_state = WB;
      end
      MEM: begin
        if (is_sw)                    next_state = FETCH;
        else if (mem_cnt == MEM_LAST) next_state = WB;
      end
      WB:      next_state = FETCH;
      default: next_state = FETCH;
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    active       = (next_state inside {EXEC, MEM, WB});
    reg_dst_d    = active && is_rtype;
    alu_src_d    = active && (is_lw || is_sw || is_addi);
    alu_ctl_d    = active ? dec_alu_ctl : ALU_ADD;
    mem_to_reg_d = active ? !is_lw : 1'b1;
    reg_write_d  = (next_state == WB);
    mem_write_d  = (next_state == MEM) && is_sw;
    mem_read_d   = is_lw && ((next_state == MEM) || (next_state == WB));
    done_d       = (next_state == FETCH) && (state inside {EXEC, MEM, WB});
    illegal_d    = (state == DECODE) && dec_illegal;
    branch_d     = (state == EXEC) && is_beq && eq;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cnt <= 4'd0;
    end else if (state == EXEC) begin
      mem_cnt <= 4'd0;
    end else if (state == MEM) begin
      mem_cnt <= mem_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Instr        <= 32'd0;
      Reg_Dst      <= 1'b0;
      Reg_Write    <= 1'b0;
      Alu_Src      <= 1'b0;
      Alu_Control  <= ALU_ADD;
      Mem_Write    <= 1'b0;
      Mem_Read     <= 1'b0;
      Mem_To_Reg   <= 1'b1;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (state == FETCH && instr_valid) Instr <= instr_in;
      Reg_Dst      <= reg_dst_d;
      Reg_Write    <= reg_write_d;
      Alu_Src      <= alu_src_d;
      Alu_Control  <= alu_ctl_d;
      Mem_Write    <= mem_write_d;
      Mem_Read     <= mem_read_d;
      Mem_To_Reg   <= mem_to_reg_d;
      branch_taken <= branch_d;
      illegal      <= illegal_d;
      done         <= done_d;
    end
  end

endmodule
